// File: rtl/dplca_txop_table.sv
// dplca_txop_table: Dynamic-PLCA TXOP occupancy table.
// Captures the claim reported at each TXOP end, ages all entries once per
// PLCA cycle (detected as a non-increasing TXOP id), and publishes the
// node count, the lowest free id and a table-updated handshake.
// Optional feature macro: DPLCA_TXOP_AGING_EN (enables per-cycle aging;
// when undefined, claims load a permanent age of 1 and aging stays OFF).
module dplca_txop_table #(
  parameter int MAX_IDS      = 32,
  parameter int AGING_CYCLES = 8
) (
  input  logic       clk,
  input  logic       plca_reset,
  input  logic       dplca_en,
  input  logic [1:0] dplca_txop_claim,
  input  logic       dplca_txop_end,
  input  logic [7:0] dplca_txop_id,
  output logic       dplca_txop_table_upd,
  output logic       dplca_aging,
  output logic [7:0] plca_node_count,
  output logic [7:0] dplca_free_id,
  output logic       dplca_overrun
);

  localparam int IW = $clog2(MAX_IDS);
  localparam logic [3:0] CFG_AGE = 4'(AGING_CYCLES);
`ifdef DPLCA_TXOP_AGING_EN
  localparam bit AGING_ON = 1'b1;
`else
  localparam bit AGING_ON = 1'b0;
`endif
  localparam logic [3:0] HARD_AGE = AGING_ON ? CFG_AGE : 4'd1;

  typedef enum logic [1:0] {IDLE, UPDATE, SWEEP, PUBLISH} state_t;

  state_t          state_q, state_d;
  logic            end_q;
  logic            pend_v_q, pend_v_d;
  logic [1:0]      pend_claim_q, pend_claim_d;
  logic [7:0]      pend_id_q, pend_id_d;
  logic [7:0]      last_id_q, last_id_d;
  logic [3:0]      age_q [MAX_IDS];
  logic [3:0]      age_d [MAX_IDS];
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   max_occ_q, max_occ_d;
  logic [7:0]      min_free_q, min_free_d;
  logic            swept_q, swept_d;
  logic            upd_q, upd_d;
  logic            aging_q, aging_d;
  logic            overrun_q, overrun_d;
  logic [7:0]      count_q, count_d;
  logic [7:0]      free_q, free_d;

  logic            txop_edge;
  logic            in_range;
  logic            is_hard;
  logic            is_soft;
  logic            wrap;
  logic [IW-1:0]   pidx;
  logic [3:0]      cur_age;
  logic [3:0]      nxt_age;

  assign dplca_txop_table_upd = upd_q;
  assign dplca_aging          = aging_q;
  assign plca_node_count      = count_q;
  assign dplca_free_id        = free_q;
  assign dplca_overrun        = overrun_q;

  // Next-state: edge capture, table update, sweep and publish
  always_comb begin
    state_d      = state_q;
    pend_v_d     = pend_v_q;
    pend_claim_d = pend_claim_q;
    pend_id_d    = pend_id_q;
    last_id_d    = last_id_q;
    age_d        = age_q;
    idx_d        = idx_q;
    max_occ_d    = max_occ_q;
    min_free_d   = min_free_q;
    swept_d      = swept_q;
    upd_d        = upd_q;
    aging_d      = aging_q;
    overrun_d    = overrun_q;
    count_d      = count_q;
    free_d       = free_q;

    txop_edge = dplca_txop_end & ~end_q;
    in_range  = pend_id_q < 8'(MAX_IDS);
    is_hard   = pend_claim_q == 2'b10;
    is_soft   = pend_claim_q == 2'b01;
    wrap      = (pend_id_q == 8'hFF) || (pend_id_q <= last_id_q);
    pidx      = pend_id_q[IW-1:0];
    cur_age   = age_q[idx_q];
    // The entry HARD-claimed in this pass keeps its fresh age through the sweep
    if (AGING_ON && cur_age != 4'd0 && !(in_range && is_hard && idx_q == pidx))
      nxt_age = cur_age - 4'd1;
    else
      nxt_age = cur_age;

    if (txop_edge) begin
      if (pend_v_q) begin
        overrun_d = 1'b1;
      end else begin
        pend_v_d     = 1'b1;
        pend_claim_d = dplca_txop_claim;
        pend_id_d    = dplca_txop_id;
      end
    end

    case (state_q)
      IDLE: begin
        if (pend_v_q) begin
          state_d = UPDATE;
          upd_d   = 1'b0;
        end
      end
      UPDATE: begin
        if (in_range) begin
          if (is_hard)
            age_d[pidx] = HARD_AGE;
          else if (is_soft && age_q[pidx] == 4'd0)
            age_d[pidx] = 4'd1;
        end
        last_id_d = pend_id_q;
        if (wrap) begin
          state_d    = SWEEP;
          idx_d      = '0;
          max_occ_d  = '0;
          min_free_d = 8'hFF;
          swept_d    = 1'b1;
        end else begin
          state_d = PUBLISH;
          swept_d = 1'b0;
        end
      end
      SWEEP: begin
        age_d[idx_q] = nxt_age;
        if (nxt_age != 4'd0)
          max_occ_d = idx_q;
        if (idx_q != '0 && nxt_age == 4'd0 && min_free_q == 8'hFF)
          min_free_d = 8'(idx_q);
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(MAX_IDS - 1)) begin
          state_d = PUBLISH;
          if (AGING_ON)
            aging_d = 1'b1;
        end
      end
      PUBLISH: begin
        if (swept_q)
          count_d = 8'(max_occ_q) + 8'd1;
        else if (in_range && age_q[pidx] != 4'd0 && pend_id_q >= count_q)
          count_d = pend_id_q + 8'd1;
        free_d   = min_free_q;
        upd_d    = 1'b1;
        pend_v_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous clear on reset or disable
  always_ff @(posedge clk) begin
    if (plca_reset || !dplca_en) begin
      state_q      <= IDLE;
      end_q        <= 1'b0;
      pend_v_q     <= 1'b0;
      pend_claim_q <= '0;
      pend_id_q    <= '0;
      last_id_q    <= '0;
      for (int unsigned i = 0; i < MAX_IDS; i++) age_q[i] <= '0;
      idx_q        <= '0;
      max_occ_q    <= '0;
      min_free_q   <= 8'd1;
      swept_q      <= 1'b0;
      upd_q        <= 1'b0;
      aging_q      <= 1'b0;
      overrun_q    <= 1'b0;
      count_q      <= 8'd1;
      free_q       <= 8'd1;
    end else begin
      state_q      <= state_d;
      end_q        <= dplca_txop_end;
      pend_v_q     <= pend_v_d;
      pend_claim_q <= pend_claim_d;
      pend_id_q    <= pend_id_d;
      last_id_q    <= last_id_d;
      age_q        <= age_d;
      idx_q        <= idx_d;
      max_occ_q    <= max_occ_d;
      min_free_q   <= min_free_d;
      swept_q      <= swept_d;
      upd_q        <= upd_d;
      aging_q      <= aging_d;
      overrun_q    <= overrun_d;
      count_q      <= count_d;
      free_q       <= free_d;
    end
  end

endmodule

// File: tb/tb_dplca_txop_table.sv
// Testbench for dplca_txop_table: directed scenarios plus randomized TXOPs
// checked against a whole-table behavioural model.
module tb_dplca_txop_table;

  localparam int MAX_IDS = 32;
  localparam int AGING   = 8;
`ifdef DPLCA_TXOP_AGING_EN
  localparam bit AGE_EN = 1'b1;
`else
  localparam bit AGE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       plca_reset;
  logic       dplca_en;
  logic [1:0] dplca_txop_claim;
  logic       dplca_txop_end;
  logic [7:0] dplca_txop_id;
  logic       dplca_txop_table_upd;
  logic       dplca_aging;
  logic [7:0] plca_node_count;
  logic [7:0] dplca_free_id;
  logic       dplca_overrun;

  always #5 clk = ~clk;

  dplca_txop_table #(.MAX_IDS(MAX_IDS), .AGING_CYCLES(AGING)) dut (
    .clk                  (clk),
    .plca_reset           (plca_reset),
    .dplca_en             (dplca_en),
    .dplca_txop_claim     (dplca_txop_claim),
    .dplca_txop_end       (dplca_txop_end),
    .dplca_txop_id        (dplca_txop_id),
    .dplca_txop_table_upd (dplca_txop_table_upd),
    .dplca_aging          (dplca_aging),
    .plca_node_count      (plca_node_count),
    .dplca_free_id        (dplca_free_id),
    .dplca_overrun        (dplca_overrun)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: full table of ages plus published values
  int m_age [MAX_IDS];
  int m_last, m_count, m_free;
  bit m_aging, m_ovr, m_upd;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < MAX_IDS; i++) m_age[i] = 0;
    m_last = 0; m_count = 1; m_free = 1;
    m_aging = 0; m_ovr = 0; m_upd = 0;
  endfunction

  // Applies one TXOP report; returns clocks from the edge to upd rising
  function automatic int model_txop(input int claim, input int id);
    bit in_r = id < MAX_IDS;
    bit wrap;
    if (in_r) begin
      if (claim == 2) m_age[id] = AGE_EN ? AGING : 1;
      else if (claim == 1 && m_age[id] == 0) m_age[id] = 1;
    end
    wrap = (id == 255) || (id <= m_last);
    m_last = id;
    if (wrap) begin
      for (int i = 0; i < MAX_IDS; i++)
        if (AGE_EN && m_age[i] > 0 && !(in_r && claim == 2 && i == id)) m_age[i]--;
      m_count = 1;
      for (int i = 0; i < MAX_IDS; i++) if (m_age[i] > 0) m_count = i + 1;
      m_free = 255;
      for (int i = MAX_IDS - 1; i >= 1; i--) if (m_age[i] == 0) m_free = i;
      if (AGE_EN) m_aging = 1;
      return 3 + MAX_IDS;
    end
    if (in_r && m_age[id] > 0 && id + 1 > m_count) m_count = id + 1;
    return 3;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_upd"},   int'(dplca_txop_table_upd), int'(m_upd));
    check({tag, "_aging"}, int'(dplca_aging),          int'(m_aging));
    check({tag, "_count"}, int'(plca_node_count),      m_count);
    check({tag, "_free"},  int'(dplca_free_id),        m_free);
    check({tag, "_ovr"},   int'(dplca_overrun),        int'(m_ovr));
  endtask

  task automatic do_reset(input bit use_en);
    @(negedge clk);
    if (use_en) dplca_en = 1'b0;
    else        plca_reset = 1'b1;
    @(negedge clk);
    plca_reset = 1'b0;
    dplca_en   = 1'b1;
    model_reset();
    check_outputs(use_en ? "en_clr" : "rst");
  endtask

  task automatic run_txop(input string tag, input int claim, input int id);
    int exp_lat, got_lat;
    @(negedge clk);
    dplca_txop_claim = 2'(claim);
    dplca_txop_id    = 8'(id);
    dplca_txop_end   = 1'b1;
    @(posedge clk);
    #1;
    dplca_txop_end   = 1'b0;
    dplca_txop_claim = 2'($urandom);
    dplca_txop_id    = 8'($urandom);
    exp_lat = model_txop(claim, id);
    got_lat = 0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) check({tag, "_upd_fall"}, int'(dplca_txop_table_upd), 0);
      if (dplca_txop_table_upd) begin
        got_lat = k;
        break;
      end
    end
    check({tag, "_latency"}, got_lat, exp_lat);
    m_upd = 1;
    check_outputs(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rid, rsel;
    plca_reset       = 1'b1;
    dplca_en         = 1'b1;
    dplca_txop_claim = 2'b00;
    dplca_txop_end   = 1'b0;
    dplca_txop_id    = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    plca_reset = 1'b0;
    model_reset();
    check_outputs("reset");

    // HARD id 5, non-wrap, then a wrap
    run_txop("hard5", 2, 5);
    check("hard5_count_c", int'(plca_node_count), 6);
    check("hard5_free_c", int'(dplca_free_id), 1);
    run_txop("hard5_wrap", 0, 0);
    check("hard5_wrap_count_c", int'(plca_node_count), 6);

    // HARD id 3 aged out over AGING wraps
    do_reset(1'b0);
    run_txop("hard3", 2, 3);
    for (int i = 0; i < AGING; i++) run_txop("age_wrap", 0, 0);
    check("hard3_aged_count", int'(plca_node_count), AGE_EN ? 1 : 4);
    check("hard3_aging_on", int'(dplca_aging), AGE_EN ? 1 : 0);

    // SOFT id 2 lasts until the next sweep
    do_reset(1'b0);
    run_txop("hard1", 2, 1);
    run_txop("soft2", 1, 2);
    run_txop("soft2_wrap", 0, 0);
    check("soft2_free_c", int'(dplca_free_id), AGE_EN ? 2 : 3);

    // Second edge during SWEEP is dropped and flagged
    do_reset(1'b0);
    run_txop("pre_ovr", 2, 4);
    @(negedge clk);
    dplca_txop_claim = 2'b00; dplca_txop_id = 8'd0; dplca_txop_end = 1'b1;
    @(posedge clk); #1; dplca_txop_end = 1'b0;
    void'(model_txop(0, 0));
    repeat (6) @(posedge clk);
    @(negedge clk);
    dplca_txop_claim = 2'b10; dplca_txop_id = 8'd9; dplca_txop_end = 1'b1;
    @(posedge clk); #1; dplca_txop_end = 1'b0;
    check("ovr_flag", int'(dplca_overrun), 1);
    m_ovr = 1;
    for (int k = 0; k < 300 && !dplca_txop_table_upd; k++) begin
      @(posedge clk); #1;
    end
    check("ovr_done", int'(dplca_txop_table_upd), 1);
    m_upd = 1;
    check_outputs("ovr");
    run_txop("post_ovr", 0, 0);

    // Reset pulse mid-sweep, then a normal transaction
    @(negedge clk);
    dplca_txop_claim = 2'b00; dplca_txop_id = 8'd0; dplca_txop_end = 1'b1;
    @(posedge clk); #1; dplca_txop_end = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    plca_reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check_outputs("mid_rst");
    @(negedge clk);
    plca_reset = 1'b0;
    run_txop("after_rst", 2, 4);

    // Disable acts as a clear
    do_reset(1'b1);

    // HARD id 7 across 20 wraps
    run_txop("hard7", 2, 7);
    for (int i = 0; i < 20; i++) run_txop("h7_wrap", 0, 0);
    check("hard7_count_c", int'(plca_node_count), AGE_EN ? 1 : 8);

    // Randomized TXOP reports
    do_reset(1'b0);
    for (int n = 0; n < 60; n++) begin
      rsel = int'($urandom_range(0, 9));
      if (rsel == 0)     rid = 255;
      else if (rsel < 3) rid = int'($urandom_range(MAX_IDS, 254));
      else               rid = int'($urandom_range(0, MAX_IDS - 1));
      run_txop("rand", int'($urandom_range(0, 3)), rid);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
